// File: rtl/nn_params.sv
// Shared NN tapeout parameters: image geometry, read-coordinate width and the
// frame loader state encoding (also used by conv2d_layer).
package nn_params;

  localparam int unsigned IMG_W   = 8;
  localparam int unsigned IMG_H   = 8;
  localparam int unsigned COORD_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } loader_state_e;

endpackage

// File: rtl/pin_edge_sync.sv
// Two-flop synchronizer followed by a rise detector for an asynchronous pin.
// Ports:
//   clk, reset  - design clock, synchronous active-high reset
//   pin_i       - asynchronous input pin
//   rise_c_o    - one-cycle pulse (combinational) on a synchronized 0->1 edge
module pin_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic rise_c_o
);

  logic meta_q, sync_q, prev_q;

  // Synchronizer chain plus previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c_o = sync_q & ~prev_q;

endmodule

// File: rtl/image_loader.sv
// Binary 8x8 frame receiver: collects row bytes paced by a strobe pin into a
// frame buffer, holds the frame until consumed, and offers a zero-padded
// combinational pixel read port for the convolution window.
// Ports:
//   clk, reset      - design clock, synchronous active-high reset
//   data_in         - row byte, bit x is pixel (x, row)
//   data_strobe     - async pin, rising edge delivers one row
//   frame_start     - async pin, rising edge starts a new frame
//   frame_consumed  - one-cycle pulse, frame has been used
//   rd_x, rd_y      - signed read coordinates
//   rd_pixel        - combinational pixel, 0 outside the image
//   image_bits      - frame buffer, bit y*IMG_W+x
//   loading_done    - high while a complete frame is held
//   row_count       - rows received in the current frame
//   overrun         - sticky, strobe seen while a frame was held
module image_loader #(
  parameter int unsigned IMG_W   = nn_params::IMG_W,
  parameter int unsigned IMG_H   = nn_params::IMG_H,
  parameter int unsigned COORD_W = nn_params::COORD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IMG_W-1:0]           data_in,
  input  logic                       data_strobe,
  input  logic                       frame_start,
  input  logic                       frame_consumed,
  input  logic signed [COORD_W-1:0]  rd_x,
  input  logic signed [COORD_W-1:0]  rd_y,
  output logic                       rd_pixel,
  output logic [IMG_W*IMG_H-1:0]     image_bits,
  output logic                       loading_done,
  output logic [3:0]                 row_count,
  output logic                       overrun
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned XW   = $clog2(IMG_W);
  localparam int unsigned YW   = $clog2(IMG_H);

  nn_params::loader_state_e state_q, state_d;
  logic [NPIX-1:0] bits_q, bits_d;
  logic [3:0]      row_q, row_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;

  logic strobe_rise_c, start_rise_c;

  pin_edge_sync u_strobe_sync (
    .clk      (clk),
    .reset    (reset),
    .pin_i    (data_strobe),
    .rise_c_o (strobe_rise_c)
  );

  pin_edge_sync u_start_sync (
    .clk      (clk),
    .reset    (reset),
    .pin_i    (frame_start),
    .rise_c_o (start_rise_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= nn_params::IDLE;
      bits_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      row_q   <= row_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, row writer; frame_start has priority over everything else.
  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    row_d   = row_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    if (start_rise_c) begin
      state_d = nn_params::LOAD;
      bits_d  = '0;
      row_d   = '0;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        nn_params::LOAD: begin
          if (strobe_rise_c) begin
            for (int r = 0; r < int'(IMG_H); r++) begin
              if (row_q == 4'(r)) bits_d[r*IMG_W +: IMG_W] = data_in;
            end
            if (row_q != 4'(IMG_H)) row_d = row_q + 4'd1;
            if (row_q == 4'(IMG_H - 1)) begin
              state_d = nn_params::READY;
              done_d  = 1'b1;
            end
          end
        end
        nn_params::READY: begin
          if (strobe_rise_c) ovr_d = 1'b1;
          if (frame_consumed) begin
            state_d = nn_params::IDLE;
            done_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Zero-padded read: negative (sign bit) or beyond the last column/row reads 0.
  logic          x_in_c, y_in_c;
  logic [AW-1:0] idx_c;

  assign x_in_c = !rd_x[COORD_W-1] && (rd_x <= $signed(COORD_W'(IMG_W - 1)));
  assign y_in_c = !rd_y[COORD_W-1] && (rd_y <= $signed(COORD_W'(IMG_H - 1)));
  assign idx_c  = AW'(rd_y[YW-1:0]) * AW'(IMG_W) + AW'(rd_x[XW-1:0]);

  assign rd_pixel     = x_in_c & y_in_c & bits_q[idx_c];
  assign image_bits   = bits_q;
  assign loading_done = done_q;
  assign row_count    = row_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader.
module tb_image_loader;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        data_in;
  logic              data_strobe;
  logic              frame_start;
  logic              frame_consumed;
  logic signed [4:0] rd_x, rd_y;
  logic              rd_pixel;
  logic [63:0]       image_bits;
  logic              loading_done;
  logic [3:0]        row_count;
  logic              overrun;

  int n_checks = 0;
  int n_fail   = 0;

  image_loader dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_strobe    (data_strobe),
    .frame_start    (frame_start),
    .frame_consumed (frame_consumed),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_pixel       (rd_pixel),
    .image_bits     (image_bits),
    .loading_done   (loading_done),
    .row_count      (row_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: pins held 3 cycles high, 3 low (above minimum widths).
  task automatic send_row(input logic [7:0] b);
    @(negedge clk);
    data_in = b; data_strobe = 1'b1;
    repeat (3) @(negedge clk);
    data_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    repeat (3) @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_consumed();
    @(negedge clk);
    frame_consumed = 1'b1;
    @(negedge clk);
    frame_consumed = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (image_bits !== 64'h0) begin n_fail++; $display("FAIL reset_bits: got %h exp 0", image_bits); end
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", loading_done); end
    n_checks++; if (row_count !== 4'd0) begin n_fail++; $display("FAIL reset_rows: got %0d exp 0", row_count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load();
    logic [7:0] b;
    pulse_start();
    n_checks++; if (row_count !== 4'd0) begin n_fail++; $display("FAIL load_start_rows: got %0d exp 0", row_count); end
    for (int i = 0; i < 7; i++) begin
      b = 8'h01 << i;
      send_row(b);
      n_checks++; if (row_count !== 4'(i + 1)) begin n_fail++; $display("FAIL load_rows_%0d: got %0d exp %0d", i, row_count, i + 1); end
    end
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL load_done_early: got %b exp 0", loading_done); end
    // 8th row: watch loading_done across the three sampling edges
    @(negedge clk);
    data_in = 8'h80; data_strobe = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL load_done_e0: got %b exp 0", loading_done); end
    @(posedge clk); #1;
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL load_done_e1: got %b exp 0", loading_done); end
    @(posedge clk); #1;
    n_checks++; if (loading_done !== 1'b1) begin n_fail++; $display("FAIL load_done_e2: got %b exp 1", loading_done); end
    @(negedge clk);
    data_strobe = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (image_bits !== 64'h8040201008040201) begin n_fail++; $display("FAIL load_bits: got %h exp 8040201008040201", image_bits); end
    n_checks++; if (row_count !== 4'd8) begin n_fail++; $display("FAIL load_rows_final: got %0d exp 8", row_count); end
  endtask

  task automatic test_reads();
    logic signed [4:0] xs [7] = '{5'sd3, 5'sd2, -5'sd1, 5'sd8, 5'sd0, 5'sd7, 5'sd5};
    logic signed [4:0] ys [7] = '{5'sd3, 5'sd3, 5'sd0, 5'sd7, -5'sd1, 5'sd7, 5'sd5};
    logic              ex [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      rd_x = xs[i]; rd_y = ys[i];
      #1;
      n_checks++; if (rd_pixel !== ex[i]) begin n_fail++; $display("FAIL read_%0d (%0d,%0d): got %b exp %b", i, xs[i], ys[i], rd_pixel, ex[i]); end
    end
  endtask

  task automatic test_overrun();
    send_row(8'hFF);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b exp 1", overrun); end
    n_checks++; if (image_bits !== 64'h8040201008040201) begin n_fail++; $display("FAIL ovr_bits: got %h exp 8040201008040201", image_bits); end
    n_checks++; if (loading_done !== 1'b1) begin n_fail++; $display("FAIL ovr_done: got %b exp 1", loading_done); end
    pulse_consumed();
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL consume_done: got %b exp 0", loading_done); end
    // In IDLE a strobe is ignored; buffer retained, overrun stays sticky
    send_row(8'h0F);
    n_checks++; if (row_count !== 4'd8) begin n_fail++; $display("FAIL idle_rows: got %0d exp 8", row_count); end
    n_checks++; if (image_bits !== 64'h8040201008040201) begin n_fail++; $display("FAIL idle_bits: got %h exp 8040201008040201", image_bits); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL idle_overrun: got %b exp 1", overrun); end
  endtask

  task automatic test_restart();
    pulse_start();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL restart_ovr_clear: got %b exp 0", overrun); end
    repeat (4) send_row(8'hAA);
    n_checks++; if (image_bits !== 64'h00000000AAAAAAAA) begin n_fail++; $display("FAIL partial_bits: got %h exp 00000000aaaaaaaa", image_bits); end
    // frame_consumed outside READY has no effect
    pulse_consumed();
    n_checks++; if (row_count !== 4'd4) begin n_fail++; $display("FAIL consume_in_load: got %0d exp 4", row_count); end
    pulse_start();
    n_checks++; if (image_bits !== 64'h0) begin n_fail++; $display("FAIL restart_bits: got %h exp 0", image_bits); end
    n_checks++; if (row_count !== 4'd0) begin n_fail++; $display("FAIL restart_rows: got %0d exp 0", row_count); end
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b exp 0", loading_done); end
    repeat (8) send_row(8'h55);
    n_checks++; if (image_bits !== 64'h5555555555555555) begin n_fail++; $display("FAIL reload_bits: got %h exp 5555555555555555", image_bits); end
    n_checks++; if (loading_done !== 1'b1) begin n_fail++; $display("FAIL reload_done: got %b exp 1", loading_done); end
  endtask

  task automatic test_simultaneous();
    // frame_start and strobe rise together from READY: start wins, byte dropped
    @(negedge clk);
    data_in = 8'hFF; data_strobe = 1'b1; frame_start = 1'b1;
    repeat (3) @(negedge clk);
    data_strobe = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (row_count !== 4'd0) begin n_fail++; $display("FAIL simul_rows: got %0d exp 0", row_count); end
    n_checks++; if (image_bits !== 64'h0) begin n_fail++; $display("FAIL simul_bits: got %h exp 0", image_bits); end
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL simul_done: got %b exp 0", loading_done); end
    // A strobe held high for 10 cycles is one row
    @(negedge clk);
    data_in = 8'h3C; data_strobe = 1'b1;
    repeat (10) @(negedge clk);
    data_strobe = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (row_count !== 4'd1) begin n_fail++; $display("FAIL held_rows: got %0d exp 1", row_count); end
    n_checks++; if (image_bits !== 64'h3C) begin n_fail++; $display("FAIL held_bits: got %h exp 3c", image_bits); end
    rd_x = 5'sd2; rd_y = 5'sd0; #1;
    n_checks++; if (rd_pixel !== 1'b1) begin n_fail++; $display("FAIL held_read_2_0: got %b exp 1", rd_pixel); end
    rd_x = 5'sd1; #1;
    n_checks++; if (rd_pixel !== 1'b0) begin n_fail++; $display("FAIL held_read_1_0: got %b exp 0", rd_pixel); end
  endtask

  task automatic test_reset_midload();
    repeat (4) send_row(8'h77);
    n_checks++; if (row_count !== 4'd5) begin n_fail++; $display("FAIL mid_rows: got %0d exp 5", row_count); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (image_bits !== 64'h0) begin n_fail++; $display("FAIL mid_reset_bits: got %h exp 0", image_bits); end
    n_checks++; if (row_count !== 4'd0) begin n_fail++; $display("FAIL mid_reset_rows: got %0d exp 0", row_count); end
    n_checks++; if ((loading_done | overrun) !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b%b exp 00", loading_done, overrun); end
    @(negedge clk);
    reset = 1'b0;
    send_row(8'h12);
    send_row(8'h34);
    n_checks++; if (row_count !== 4'd0) begin n_fail++; $display("FAIL nostart_rows: got %0d exp 0", row_count); end
    n_checks++; if (image_bits !== 64'h0) begin n_fail++; $display("FAIL nostart_bits: got %h exp 0", image_bits); end
  endtask

  task automatic test_consume_with_strobe();
    pulse_start();
    repeat (8) send_row(8'hC3);
    n_checks++; if (image_bits !== 64'hC3C3C3C3C3C3C3C3) begin n_fail++; $display("FAIL cs_bits: got %h exp c3c3c3c3c3c3c3c3", image_bits); end
    // Strobe rise lands on the same edge as frame_consumed
    @(negedge clk);
    data_in = 8'hEE; data_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_consumed = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (loading_done !== 1'b0) begin n_fail++; $display("FAIL cs_done: got %b exp 0", loading_done); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL cs_overrun: got %b exp 1", overrun); end
    @(negedge clk);
    frame_consumed = 1'b0;
    @(negedge clk);
    data_strobe = 1'b0;
    repeat (3) @(negedge clk);
    send_row(8'h00);
    n_checks++; if (image_bits !== 64'hC3C3C3C3C3C3C3C3) begin n_fail++; $display("FAIL cs_idle_bits: got %h exp c3c3c3c3c3c3c3c3", image_bits); end
    n_checks++; if (row_count !== 4'd8) begin n_fail++; $display("FAIL cs_idle_rows: got %0d exp 8", row_count); end
  endtask

  initial begin
    reset = 1'b1; data_in = '0; data_strobe = 1'b0; frame_start = 1'b0;
    frame_consumed = 1'b0; rd_x = '0; rd_y = '0;
    test_reset();
    test_load();
    test_reads();
    test_overrun();
    test_restart();
    test_simultaneous();
    test_reset_midload();
    test_consume_with_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_loader.md
# image_loader

Front-end frame receiver for the NN tapeout top (`tt_um_mark28277`). It gathers one binary 8x8 image, sent over `ui_in` as eight row bytes, into a 64-bit frame buffer. A strobe pin on `uio_in` paces the bytes. It drives `loading_done` into `conv2d_layer.start_processing` and provides a zero-padded pixel read port for the convolution window. It holds the frame until the convolution signals consumption, then re-arms for the next image.

## Interface
Parameters:
- `IMG_W`, 8, pixels per row; also the width of `data_in`.
- `IMG_H`, 8, rows per frame.
- `COORD_W`, 5, width of the signed read coordinates.

Ports:
- `clk`  in  1  single design clock.
- `reset`  in  1  synchronous, active-high reset (top derives it as `~rst_n`).
- `data_in`  in  `IMG_W`  row byte; bit x is pixel (x, row).
- `data_strobe`  in  1  asynchronous pin; a rising edge delivers one row.
- `frame_start`  in  1  asynchronous pin; a rising edge begins a new frame.
- `frame_consumed`  in  1  synchronous one-cycle pulse from the convolution when its last position is done.
- `rd_x`, `rd_y`  in  `COORD_W` each  signed pixel coordinates.
- `rd_pixel`  out  1  combinational pixel at (`rd_x`, `rd_y`); 0 when the coordinate is outside the image.
- `image_bits`  out  `IMG_W*IMG_H`  frame buffer; bit index is y*`IMG_W`+x.
- `loading_done`  out  1  level; high while a complete frame is held.
- `row_count`  out  4  rows received in the current frame (0..`IMG_H`).
- `overrun`  out  1  sticky; a strobe arrived while in READY.

## Operation
- Reset values: state IDLE; `image_bits`=0, `loading_done`=0, `row_count`=0, `overrun`=0; all synchronizer flops 0. Reset asserted mid-load discards the partial frame.
- Each pin passes through a 2-flop synchronizer and then a rise detector (previous-value flop); `rise` = sync & ~prev.
- State IDLE:
  - `frame_start` rise: go to LOAD; clear `image_bits`, `row_count` and `overrun`.
  - `data_strobe` rises are ignored and no flag is set.
- State LOAD, on a `data_strobe` rise:
  - write `data_in` into row `row_count` (bits `row_count`*`IMG_W` +: `IMG_W`);
  - increment `row_count`;
  - on the `IMG_H`-th row, go to READY and set `loading_done`=1 on the same edge.
- State READY:
  - `loading_done` stays high and the frame is frozen.
  - `data_strobe` rise: sets `overrun`; the buffer is unchanged.
  - `frame_consumed`: go to IDLE and clear `loading_done`. `image_bits` is retained until the next `frame_start`.
- A `frame_start` rise in any state restarts the frame: go to LOAD, clear the buffer, `row_count` and `overrun`, and drop `loading_done`.
- Simultaneous `frame_start` and `data_strobe` rises: `frame_start` wins and the byte is dropped.
- `frame_consumed` outside READY is ignored.
- `frame_consumed` together with a `data_strobe` rise in READY: go to IDLE, set `overrun`.
- `rd_pixel` logic:
  - If `rd_x` or `rd_y` is < 0 or > `IMG_W`-1 / `IMG_H`-1, output 0.
  - Otherwise output `image_bits`[`rd_y`*`IMG_W`+`rd_x`].
  - It reads the current buffer in every state and is purely combinational.
- `row_count` saturates at `IMG_H`; it never wraps.

## Timing
- Pin to action latency: a pin first sampled high at edge E0 is seen as a rise in the cycle after E1 and acts at edge E2.
  - `data_in` is sampled at E2.
  - The host holds `data_in` stable from before E0 through E2.
- Pin pulse widths:
  - Minimum high and low time on each pin: 2 clock cycles.
  - A pin held high produces exactly one rise.
- `loading_done` rises on the same edge as the 8th row write, i.e. 3 edges after the 8th strobe is first sampled high.
- `loading_done` falls on the edge that samples `frame_consumed` or the `frame_start` rise.
- `rd_pixel` has zero-cycle latency from `rd_x`, `rd_y` and `image_bits`.

## Structure
- Shared package/header `nn_params`: `IMG_W`, `IMG_H`, the state encoding (IDLE=2'd0, LOAD=2'd1, READY=2'd2), and the `COORD_W` signed coordinate width. `conv2d_layer` also uses these.
- Sub-module `pin_edge_sync`: 2-flop synchronizer plus rise detector, reset to 0. Instantiated twice, for `data_strobe` and `frame_start`.
- The remainder (FSM, row writer, padding read mux) lives in `image_loader`, with no memories: registers only.

## Test plan
- Reset, then a `frame_start` pulse followed by 8 strobes with rows 8'h01, 8'h02 … 8'h80 -> after the 8th: `image_bits`=64'h8040201008040201, `loading_done`=1, `row_count`=8. `loading_done` must rise exactly 3 edges after the 8th strobe is first sampled high.
- Reads on the frame above:
  - (`rd_x`,`rd_y`)=(3,3) -> 1; (2,3) -> 0.
  - (-1,0) -> 0, (8,7) -> 0, (0,-1) -> 0.
  - (7,7) -> 1.
- READY, then a 9th strobe with `data_in`=8'hFF -> `overrun`=1 and `image_bits` unchanged. A `frame_consumed` pulse -> `loading_done`=0 and the state is IDLE.
- 4 rows of 8'hAA loaded, then `frame_start` -> `image_bits`=0, `row_count`=0, `loading_done`=0. 8 rows of 8'h55 -> all rows 8'h55.
- `frame_start` and `data_strobe` rising on the same clock with `data_in`=8'hFF -> `row_count`=0 and the buffer stays 0. A strobe held high for 10 cycles counts as exactly one row.
- `reset` asserted after 5 rows -> every output returns to its reset value on the next edge. Strobes sent without a `frame_start` are ignored.
